// File: rtl/fir_coef_loader_if.sv
// rtl/fir_coef_loader_if.sv - coefficient configuration stream between the source and fir_coef_loader
interface fir_coef_loader_if #(
  parameter int COEF_W = 16
) ();
  logic              cfg_valid;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - shadow-buffered FIR coefficient loader with atomic commit
// Header word sets the tap count, coefficient words fill a shadow bank, one COMMIT cycle swaps it in.
module fir_coef_loader #(
  parameter int COEF_W   = 16,
  parameter int MAX_TAPS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_enable,
  fir_coef_loader_if.slave           cfg,
  output logic [MAX_TAPS*COEF_W-1:0] coef_flat,
  output logic [3:0]                 tap_num,
  output logic                       cfg_done,
  output logic                       cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_COEF   = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [COEF_W-1:0]           r_shadow [MAX_TAPS];
  logic [3:0]                  r_shadow_tap;
  logic [3:0]                  r_index;
  logic [MAX_TAPS*COEF_W-1:0]  r_coef_flat;
  logic [3:0]                  r_tap_num;
  logic                        r_done;
  logic                        r_error;
  logic                        w_ready;
  logic                        w_xfer;
  logic                        w_abort;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (config_enable) w_next = S_HEADER;
      end
      S_HEADER: begin
        if (!config_enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_ready = 1'b1;
          if (cfg.cfg_valid) w_next = S_COEF;
        end
      end
      S_COEF: begin
        if (!config_enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_ready = 1'b1;
          if (cfg.cfg_valid && (r_index == r_shadow_tap)) w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Commit is unconditional: losing config_enable here must not tear the swap.
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!config_enable) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_xfer        = w_ready && cfg.cfg_valid;
  assign cfg.cfg_ready = w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shadow_tap <= 4'd0;
      r_index      <= 4'd0;
      r_coef_flat  <= '0;
      r_tap_num    <= 4'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      for (int k = 0; k < MAX_TAPS; k++) r_shadow[k] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_COMMIT);
      r_error <= w_abort;

      // Clearing the shadow on the header makes unloaded taps read as zero after commit.
      if ((r_state == S_HEADER) && w_xfer) begin
        r_shadow_tap <= cfg.cfg_data[3:0];
        r_index      <= 4'd0;
        for (int k = 0; k < MAX_TAPS; k++) r_shadow[k] <= '0;
      end

      if ((r_state == S_COEF) && w_xfer) begin
        r_shadow[r_index] <= cfg.cfg_data;
        if (r_index != r_shadow_tap) r_index <= r_index + 4'd1;
      end

      if (r_state == S_COMMIT) begin
        r_tap_num <= r_shadow_tap;
        for (int k = 0; k < MAX_TAPS; k++) r_coef_flat[k*COEF_W +: COEF_W] <= r_shadow[k];
      end

      if (w_abort) begin
        r_shadow_tap <= 4'd0;
        r_index      <= 4'd0;
        for (int k = 0; k < MAX_TAPS; k++) r_shadow[k] <= '0;
      end
    end
  end

  assign coef_flat = r_coef_flat;
  assign tap_num   = r_tap_num;
  assign cfg_done  = r_done;
  assign cfg_error = r_error;

endmodule
